// File: rtl/rtc_pkg.sv
// RTC update scheduler shared definitions: command codes, strobe indices,
// payload field positions and the command queue entry.
package rtc_pkg;

    typedef enum logic [2:0] {
        CMD_CLOCK       = 3'd0,
        CMD_CALIBRE     = 3'd1,
        CMD_TIMER       = 3'd2,
        CMD_ALARM_CLOCK = 3'd3,
        CMD_ALARM_DATE  = 3'd4,
        CMD_EVT_CLR     = 3'd5,
        CMD_RSV6        = 3'd6,
        CMD_RSV7        = 3'd7
    } rtc_cmd_e;

    // Strobe bit index equals the command code
    localparam int STB_W           = 6;
    localparam int STB_CLOCK       = 0;
    localparam int STB_CALIBRE     = 1;
    localparam int STB_TIMER       = 2;
    localparam int STB_ALARM_CLOCK = 3;
    localparam int STB_ALARM_DATE  = 4;
    localparam int STB_EVT_CLR     = 5;

    // Payload field positions (payload is forwarded untouched)
    localparam int CLOCK_TIME_LSB   = 0;
    localparam int CLOCK_TIME_MSB   = 21;
    localparam int CLOCK_INIT_LSB   = 22;
    localparam int CLOCK_INIT_MSB   = 31;
    localparam int CALIBRE_LSB      = 0;
    localparam int CALIBRE_MSB      = 15;
    localparam int TIMER_TARGET_LSB = 0;
    localparam int TIMER_TARGET_MSB = 16;
    localparam int TIMER_EN_BIT     = 17;
    localparam int TIMER_RETRIG_BIT = 18;
    localparam int ALM_TIME_LSB     = 0;
    localparam int ALM_TIME_MSB     = 21;
    localparam int ALM_MASK_LSB     = 22;
    localparam int ALM_MASK_MSB     = 27;
    localparam int ALM_EN_BIT       = 28;
    localparam int ALM_DATE_LSB     = 0;
    localparam int ALM_DATE_MSB     = 31;
    localparam int EVT_CLR_LSB      = 0;
    localparam int EVT_CLR_MSB      = 1;

    // One queued command: who asked, what, and the payload
    typedef struct packed {
        logic        src;
        rtc_cmd_e    cmd;
        logic [31:0] data;
    } rtc_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ISSUE = 2'd2
    } sched_state_e;

    function automatic logic is_reserved(rtc_cmd_e c);
        return (c == CMD_RSV6) || (c == CMD_RSV7);
    endfunction

    // Commands that touch the date/time registers must wait out a day rollover
    function automatic logic needs_hold(rtc_cmd_e c);
        return (c == CMD_CLOCK) || (c == CMD_ALARM_DATE);
    endfunction

endpackage

// File: rtl/rtc_cmd_fifo.sv
// Synchronous command FIFO with explicit occupancy count; pointers wrap at DEPTH.
module rtc_cmd_fifo
    import rtc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  rtc_entry_t               push_data_i,
    input  logic                     pop_i,
    output rtc_entry_t               head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    rtc_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];
    assign count_o = count;

    // Pointer and count bookkeeping; reset discards everything queued
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: empty is decided by the count alone
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data_i;
        end
    end

endmodule

// File: rtl/rtc_update_sched.sv
// RTC update scheduler: round-robin arbiter for two requesters, command queue,
// and IDLE/HOLD/ISSUE issue FSM that defers CLOCK/ALARM_DATE over day rollover.
// Optional macro RTC_SCHED_ERR_EN: reserved commands set sticky err_o and pulse done_o.
module rtc_update_sched
    import rtc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        a_req_i,
    input  logic [2:0]  a_cmd_i,
    input  logic [31:0] a_data_i,
    output logic        a_gnt_o,
    input  logic        b_req_i,
    input  logic [2:0]  b_cmd_i,
    input  logic [31:0] b_data_i,
    output logic        b_gnt_o,
    input  logic        day_rollover_i,
    output logic [5:0]  upd_strobe_o,
    output logic [31:0] upd_data_o,
    output logic        done_o,
    output logic        done_src_o,
    output logic        busy_o,
    output logic        err_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CW-1:0] q_count;
    logic [CW-1:0] count_n;
    logic          q_empty;
    logic          q_full;
    rtc_entry_t    q_head;
    rtc_entry_t    push_entry;
    rtc_entry_t    issue_q;
    logic          grant_a;
    logic          grant_b;
    logic          push;
    logic          pop;
    logic          rr_prefer_b;
    sched_state_e  state_q;
    sched_state_e  state_n;
    logic [5:0]    strobe_n;
    logic [31:0]   data_n;
    logic          done_n;
    logic          done_src_n;
    logic          busy_n;

    rtc_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .empty_o     (q_empty),
        .full_o      (q_full)
    );

    // Round-robin grant against the pre-pop occupancy
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!q_full) begin
            if (a_req_i && b_req_i) begin
                grant_a = !rr_prefer_b;
                grant_b = rr_prefer_b;
            end else begin
                grant_a = a_req_i;
                grant_b = b_req_i;
            end
        end
        push = grant_a || grant_b;
        if (grant_b) begin
            push_entry = '{src: 1'b1, cmd: rtc_cmd_e'(b_cmd_i), data: b_data_i};
        end else begin
            push_entry = '{src: 1'b0, cmd: rtc_cmd_e'(a_cmd_i), data: a_data_i};
        end
    end

    // Issue FSM next state: hold date-sensitive heads while rollover is active
    always_comb begin
        state_n = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    if (needs_hold(q_head.cmd) && day_rollover_i) begin
                        state_n = ST_HOLD;
                    end else begin
                        pop     = 1'b1;
                        state_n = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                if (!day_rollover_i) begin
                    pop     = 1'b1;
                    state_n = ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        strobe_n   = '0;
        data_n     = '0;
        done_n     = 1'b0;
        done_src_n = 1'b0;
        if (state_q == ST_ISSUE) begin
            if (!is_reserved(issue_q.cmd)) begin
                strobe_n   = 6'b000001 << issue_q.cmd;
                data_n     = issue_q.data;
                done_n     = 1'b1;
                done_src_n = issue_q.src;
            end
`ifdef RTC_SCHED_ERR_EN
            else begin
                done_n     = 1'b1;
                done_src_n = issue_q.src;
            end
`endif
        end
        count_n = q_count + CW'(push) - CW'(pop);
        busy_n  = (count_n != '0) || (state_n != ST_IDLE);
    end

    // State, popped command, arbitration pointer and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            issue_q      <= '0;
            rr_prefer_b  <= 1'b0;
            a_gnt_o      <= 1'b0;
            b_gnt_o      <= 1'b0;
            upd_strobe_o <= '0;
            upd_data_o   <= '0;
            done_o       <= 1'b0;
            done_src_o   <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            state_q <= state_n;
            if (pop) begin
                issue_q <= q_head;
            end
            if (grant_a) begin
                rr_prefer_b <= 1'b1;
            end else if (grant_b) begin
                rr_prefer_b <= 1'b0;
            end
            a_gnt_o      <= grant_a;
            b_gnt_o      <= grant_b;
            upd_strobe_o <= strobe_n;
            upd_data_o   <= data_n;
            done_o       <= done_n;
            done_src_o   <= done_src_n;
            busy_o       <= busy_n;
        end
    end

`ifdef RTC_SCHED_ERR_EN
    // Sticky error on any reserved command reaching the issue stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if ((state_q == ST_ISSUE) && is_reserved(issue_q.cmd)) begin
            err_o <= 1'b1;
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_update_sched.sv
// Self-checking bench for rtc_update_sched: directed scenarios plus a randomized
// run against a queue-level reference model. Honours RTC_SCHED_ERR_EN.
module tb_rtc_update_sched;

`ifdef RTC_SCHED_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        src;
        logic [2:0]  cmd;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        int   cyc;
        cmd_t c;
        logic a_req;
        logic b_req;
    } grant_rec_t;

    typedef struct {
        int          cyc;
        logic [5:0]  stb;
        logic [31:0] data;
        logic        done;
        logic        src;
    } issue_rec_t;

    typedef struct {
        int          gcyc;
        logic [5:0]  stb;
        logic [31:0] data;
        logic        done;
        logic        src;
    } exp_rec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        a_req_i = 1'b0;
    logic [2:0]  a_cmd_i = '0;
    logic [31:0] a_data_i = '0;
    logic        a_gnt_o;
    logic        b_req_i = 1'b0;
    logic [2:0]  b_cmd_i = '0;
    logic [31:0] b_data_i = '0;
    logic        b_gnt_o;
    logic        day_rollover_i = 1'b0;
    logic [5:0]  upd_strobe_o;
    logic [31:0] upd_data_o;
    logic        done_o;
    logic        done_src_o;
    logic        busy_o;
    logic        err_o;

    int compared = 0;
    int mismatched = 0;

    cmd_t       a_pend[$];
    cmd_t       b_pend[$];
    grant_rec_t grants[$];
    issue_rec_t issues[$];
    exp_rec_t   exp_q[$];
    logic       roll_hist[$];
    logic       rollover = 1'b0;
    int         anomalies = 0;

    rtc_update_sched #(.FIFO_DEPTH(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .a_req_i        (a_req_i),
        .a_cmd_i        (a_cmd_i),
        .a_data_i       (a_data_i),
        .a_gnt_o        (a_gnt_o),
        .b_req_i        (b_req_i),
        .b_cmd_i        (b_cmd_i),
        .b_data_i       (b_data_i),
        .b_gnt_o        (b_gnt_o),
        .day_rollover_i (day_rollover_i),
        .upd_strobe_o   (upd_strobe_o),
        .upd_data_o     (upd_data_o),
        .done_o         (done_o),
        .done_src_o     (done_src_o),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    function automatic cmd_t mk(logic src, logic [2:0] cmd, logic [31:0] data);
        cmd_t c;
        c.src = src; c.cmd = cmd; c.data = data;
        return c;
    endfunction

    // Reference model: every granted command comes out once, in grant order
    function automatic void build_exp();
        exp_rec_t r;
        exp_q.delete();
        foreach (grants[i]) begin
            r.gcyc = grants[i].cyc;
            r.src  = grants[i].c.src;
            if (grants[i].c.cmd <= 3'd5) begin
                r.stb  = 6'd1 << grants[i].c.cmd;
                r.data = grants[i].c.data;
                r.done = 1'b1;
                exp_q.push_back(r);
            end else if (ERR_EN) begin
                r.stb  = '0;
                r.data = '0;
                r.done = 1'b1;
                exp_q.push_back(r);
            end
        end
    endfunction

    // One clock: drive requesters from their pending lists, then record what happened
    task automatic step();
        grant_rec_t gr;
        issue_rec_t ir;
        a_req_i = (a_pend.size() > 0);
        a_cmd_i = a_req_i ? a_pend[0].cmd : 3'd0;
        a_data_i = a_req_i ? a_pend[0].data : 32'd0;
        b_req_i = (b_pend.size() > 0);
        b_cmd_i = b_req_i ? b_pend[0].cmd : 3'd0;
        b_data_i = b_req_i ? b_pend[0].data : 32'd0;
        day_rollover_i = rollover;
        roll_hist.push_back(rollover);
        gr.a_req = a_req_i;
        gr.b_req = b_req_i;
        @(posedge clk);
        #1;
        gr.cyc = roll_hist.size() - 1;
        if (a_gnt_o && b_gnt_o) anomalies++;
        if (a_gnt_o) begin
            if (a_pend.size() > 0) gr.c = a_pend.pop_front();
            else begin gr.c = '0; anomalies++; end
            grants.push_back(gr);
        end
        if (b_gnt_o) begin
            if (b_pend.size() > 0) gr.c = b_pend.pop_front();
            else begin gr.c = '0; anomalies++; end
            grants.push_back(gr);
        end
        if (upd_strobe_o == '0 && upd_data_o != '0) anomalies++;
        if (!$onehot0(upd_strobe_o)) anomalies++;
        if (upd_strobe_o != '0 || done_o) begin
            ir.cyc = gr.cyc; ir.stb = upd_strobe_o; ir.data = upd_data_o;
            ir.done = done_o; ir.src = done_src_o;
            issues.push_back(ir);
        end
    endtask

    task automatic run_until(int n, int budget, output bit ok);
        int k = 0;
        while (issues.size() < n && k < budget) begin
            step();
            k++;
        end
        ok = (issues.size() >= n);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        rollover = 1'b0;
        a_pend.delete(); b_pend.delete();
        a_req_i = 1'b0; b_req_i = 1'b0; day_rollover_i = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_i = 1'b0;
        grants.delete(); issues.delete(); roll_hist.delete();
        anomalies = 0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        #2;
        compared++;
        if ({a_gnt_o, b_gnt_o, upd_strobe_o, upd_data_o, done_o, done_src_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: got strobe=%b data=%h done=%b gnt=%b%b expected all 0",
                     upd_strobe_o, upd_data_o, done_o, a_gnt_o, b_gnt_o);
        end
        compared++;
        if ({busy_o, err_o} !== 2'b00) begin
            mismatched++;
            $display("[TB] FAIL reset_busy_err: got %b%b expected 00", busy_o, err_o);
        end
        do_reset();
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_single_calibre();
        bit ok;
        do_reset();
        a_pend.push_back(mk(1'b0, 3'd1, 32'h0000_7FFF));
        run_until(1, 10, ok);
        compared++;
        if (!ok || grants.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL calibre_issue: got issues=%0d grants=%0d expected 1/1", issues.size(), grants.size());
        end else begin
            compared++;
            if (grants[0].cyc !== 0) begin
                mismatched++;
                $display("[TB] FAIL calibre_gnt_cycle: got %0d expected 0", grants[0].cyc);
            end
            compared++;
            if (issues[0].cyc !== 2) begin
                mismatched++;
                $display("[TB] FAIL calibre_strobe_cycle: got %0d expected 2", issues[0].cyc);
            end
            compared++;
            if (issues[0].stb !== 6'b000010 || issues[0].data !== 32'h0000_7FFF
                || issues[0].done !== 1'b1 || issues[0].src !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL calibre_strobe: got stb=%b data=%h done=%b src=%b expected 000010/00007fff/1/0",
                         issues[0].stb, issues[0].data, issues[0].done, issues[0].src);
            end
        end
        step();
        compared++;
        if ({upd_strobe_o, upd_data_o, done_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL calibre_after: got strobe=%b data=%h done=%b expected 0", upd_strobe_o, upd_data_o, done_o);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_pend.push_back(mk(1'b0, 3'(i), 32'hA000_0000 + 32'(i)));
            b_pend.push_back(mk(1'b1, 3'(5 - i), 32'hB000_0000 + 32'(i)));
        end
        run_until(8, 60, ok);
        compared++;
        if (!ok || grants.size() != 8) begin
            mismatched++;
            $display("[TB] FAIL rr_count: got issues=%0d grants=%0d expected 8/8", issues.size(), grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            compared++;
            if (grants[i].c.src !== 1'(i % 2)) begin
                mismatched++;
                $display("[TB] FAIL rr_grant[%0d]: got src=%b expected %b", i, grants[i].c.src, 1'(i % 2));
            end
        end
        build_exp();
        for (int i = 0; i < issues.size() && i < exp_q.size(); i++) begin
            compared++;
            if (issues[i].stb !== exp_q[i].stb || issues[i].data !== exp_q[i].data
                || issues[i].done !== exp_q[i].done || issues[i].src !== exp_q[i].src) begin
                mismatched++;
                $display("[TB] FAIL rr_issue[%0d]: got stb=%b data=%h src=%b expected stb=%b data=%h src=%b",
                         i, issues[i].stb, issues[i].data, issues[i].src, exp_q[i].stb, exp_q[i].data, exp_q[i].src);
            end
        end
    endtask

    task automatic test_hold_full();
        bit ok;
        do_reset();
        rollover = 1'b1;
        a_pend.push_back(mk(1'b0, 3'd0, 32'h4812_3456));
        a_pend.push_back(mk(1'b0, 3'd2, 32'h0006_0100));
        a_pend.push_back(mk(1'b0, 3'd1, 32'h0000_1234));
        a_pend.push_back(mk(1'b0, 3'd5, 32'h0000_0003));
        a_pend.push_back(mk(1'b0, 3'd3, 32'h1FC1_2000));
        repeat (10) step();
        compared++;
        if (grants.size() != 4 || issues.size() != 0 || a_pend.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL hold_full: got grants=%0d issues=%0d pending=%0d expected 4/0/1",
                     grants.size(), issues.size(), a_pend.size());
        end
        compared++;
        if (busy_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL hold_busy: got %b expected 1", busy_o);
        end
        rollover = 1'b0;
        run_until(5, 40, ok);
        build_exp();
        compared++;
        if (!ok || exp_q.size() != 5 || issues.size() != 5) begin
            mismatched++;
            $display("[TB] FAIL hold_drain: got issues=%0d expected 5", issues.size());
        end
        for (int i = 0; i < issues.size() && i < exp_q.size(); i++) begin
            compared++;
            if (issues[i].stb !== exp_q[i].stb || issues[i].data !== exp_q[i].data || issues[i].done !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL hold_issue[%0d]: got stb=%b data=%h expected stb=%b data=%h",
                         i, issues[i].stb, issues[i].data, exp_q[i].stb, exp_q[i].data);
            end
        end
    endtask

    task automatic test_no_hold_timer();
        bit ok;
        do_reset();
        rollover = 1'b1;
        a_pend.push_back(mk(1'b0, 3'd2, 32'h0007_FFFF));
        run_until(1, 10, ok);
        compared++;
        if (!ok || issues[0].stb !== 6'b000100 || issues[0].cyc - grants[0].cyc != 2) begin
            mismatched++;
            $display("[TB] FAIL timer_no_hold: got ok=%b stb=%b expected 000100 two cycles after grant",
                     ok, ok ? issues[0].stb : 6'd0);
        end
        b_pend.push_back(mk(1'b1, 3'd4, 32'h2024_1231));
        repeat (8) step();
        compared++;
        if (issues.size() != 1) begin
            mismatched++;
            $display("[TB] FAIL alarm_date_held: got issues=%0d expected 1", issues.size());
        end
        rollover = 1'b0;
        run_until(2, 10, ok);
        compared++;
        if (!ok || issues[1].stb !== 6'b010000 || issues[1].data !== 32'h2024_1231 || issues[1].src !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL alarm_date_release: got ok=%b stb=%b expected 010000 src 1",
                     ok, ok ? issues[1].stb : 6'd0);
        end
    endtask

    task automatic test_reserved();
        do_reset();
        a_pend.push_back(mk(1'b0, 3'd7, 32'hDEAD_BEEF));
        b_pend.push_back(mk(1'b1, 3'd1, 32'h0000_1234));
        repeat (10) step();
        build_exp();
        compared++;
        if (issues.size() != exp_q.size()) begin
            mismatched++;
            $display("[TB] FAIL reserved_count: got %0d expected %0d", issues.size(), exp_q.size());
        end
        for (int i = 0; i < issues.size() && i < exp_q.size(); i++) begin
            compared++;
            if (issues[i].stb !== exp_q[i].stb || issues[i].data !== exp_q[i].data
                || issues[i].done !== exp_q[i].done || issues[i].src !== exp_q[i].src) begin
                mismatched++;
                $display("[TB] FAIL reserved_issue[%0d]: got stb=%b data=%h done=%b src=%b expected stb=%b data=%h done=%b src=%b",
                         i, issues[i].stb, issues[i].data, issues[i].done, issues[i].src,
                         exp_q[i].stb, exp_q[i].data, exp_q[i].done, exp_q[i].src);
            end
        end
        compared++;
        if (err_o !== ERR_EN) begin
            mismatched++;
            $display("[TB] FAIL reserved_err: got %b expected %b", err_o, ERR_EN);
        end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        rollover = 1'b1;
        a_pend.push_back(mk(1'b0, 3'd0, 32'h0012_3456));
        a_pend.push_back(mk(1'b0, 3'd2, 32'h0002_0010));
        b_pend.push_back(mk(1'b1, 3'd1, 32'h0000_0042));
        repeat (6) step();
        compared++;
        if (busy_o !== 1'b1 || grants.size() != 3) begin
            mismatched++;
            $display("[TB] FAIL rst_hold_setup: got busy=%b grants=%0d expected 1/3", busy_o, grants.size());
        end
        #2 rst_i = 1'b1;
        #1;
        compared++;
        if ({a_gnt_o, b_gnt_o, upd_strobe_o, upd_data_o, done_o, done_src_o, busy_o, err_o} !== '0) begin
            mismatched++;
            $display("[TB] FAIL rst_hold_outputs: got strobe=%b busy=%b err=%b done=%b expected all 0",
                     upd_strobe_o, busy_o, err_o, done_o);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        rollover = 1'b0;
        issues.delete();
        repeat (10) step();
        compared++;
        if (issues.size() != 0 || busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rst_hold_discard: got issues=%0d busy=%b expected 0/0", issues.size(), busy_o);
        end
    endtask

    task automatic test_random();
        int   n_a = 0;
        int   n_b = 0;
        int   budget = 0;
        logic pref_b = 1'b0;
        logic want;
        do_reset();
        while ((n_a < 30 || n_b < 30 || a_pend.size() > 0 || b_pend.size() > 0) && budget < 4000) begin
            if (n_a < 30 && a_pend.size() < 3 && $urandom_range(0, 2) == 0) begin
                a_pend.push_back(mk(1'b0, 3'($urandom_range(0, 7)), $urandom));
                n_a++;
            end
            if (n_b < 30 && b_pend.size() < 3 && $urandom_range(0, 2) == 0) begin
                b_pend.push_back(mk(1'b1, 3'($urandom_range(0, 7)), $urandom));
                n_b++;
            end
            rollover = ($urandom_range(0, 9) < 3);
            step();
            budget++;
        end
        rollover = 1'b0;
        repeat (12) step();
        compared++;
        if (budget >= 4000 || grants.size() != 60) begin
            mismatched++;
            $display("[TB] FAIL rand_budget: got grants=%0d cycles=%0d expected 60 grants", grants.size(), budget);
        end
        compared++;
        if (anomalies != 0) begin
            mismatched++;
            $display("[TB] FAIL rand_anomalies: got %0d expected 0", anomalies);
        end
        foreach (grants[i]) begin
            if (grants[i].a_req && grants[i].b_req) want = pref_b;
            else want = grants[i].b_req;
            compared++;
            if (grants[i].c.src !== want) begin
                mismatched++;
                $display("[TB] FAIL rand_rr[%0d]: got src=%b expected %b", i, grants[i].c.src, want);
            end
            pref_b = ~grants[i].c.src;
        end
        build_exp();
        compared++;
        if (issues.size() != exp_q.size()) begin
            mismatched++;
            $display("[TB] FAIL rand_issue_count: got %0d expected %0d", issues.size(), exp_q.size());
        end
        for (int i = 0; i < issues.size() && i < exp_q.size(); i++) begin
            compared++;
            if (issues[i].stb !== exp_q[i].stb || issues[i].data !== exp_q[i].data
                || issues[i].done !== exp_q[i].done || issues[i].src !== exp_q[i].src
                || issues[i].cyc < exp_q[i].gcyc + 2
                || (i > 0 && issues[i].cyc < issues[i-1].cyc + 2)
                || ((issues[i].stb[0] || issues[i].stb[4]) && roll_hist[issues[i].cyc - 1] !== 1'b0)) begin
                mismatched++;
                $display("[TB] FAIL rand_issue[%0d]: got stb=%b data=%h src=%b cyc=%0d expected stb=%b data=%h src=%b after cyc %0d",
                         i, issues[i].stb, issues[i].data, issues[i].src, issues[i].cyc,
                         exp_q[i].stb, exp_q[i].data, exp_q[i].src, exp_q[i].gcyc + 1);
            end
        end
    endtask

    initial begin
        $display("[TB] rtc_update_sched bench, ERR_EN=%0d", ERR_EN);
        test_reset();
        test_single_calibre();
        test_round_robin();
        test_hold_full();
        test_no_hold_timer();
        test_reserved();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rtc_update_sched.md
RTC_UPDATE_SCHED -- requirements
Module: rtc_update_sched

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command queue depth (power of two, 2..16).
REQ-002 SHALL have port clk_i, input, 1, the single clock.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports a_req_i/b_req_i, input, 1 each, requester A (bus) and requester B (autoload/calibration) request.
REQ-005 SHALL have ports a_cmd_i/b_cmd_i, input, 3 each, command code.
REQ-006 SHALL have ports a_data_i/b_data_i, input, 32 each, command payload.
REQ-007 SHALL have ports a_gnt_o/b_gnt_o, output, 1 each, one-cycle accept pulse.
REQ-008 SHALL have port day_rollover_i, input, 1, datapath day-rollover indication (hold-off).
REQ-009 SHALL have port upd_strobe_o, output, 6, one-hot update strobe to the RTC datapath.
REQ-010 SHALL have port upd_data_o, output, 32, payload valid while the strobe is high.
REQ-011 SHALL have ports done_o, output, 1, and done_src_o, output, 1 (0=A, 1=B), indicating command issued.
REQ-012 SHALL have ports busy_o, output, 1, and err_o, output, 1, sticky error flag.

Function
REQ-013 SHALL use command codes 0 CLOCK, 1 CALIBRE, 2 TIMER, 3 ALARM_CLOCK, 4 ALARM_DATE, 5 EVT_CLR, with 6-7 reserved; strobe bit index equals code.
REQ-014 SHALL define payload fields as: CLOCK [21:0] BCD hh:mm:ss and [31:22] init sec count; CALIBRE [15:0]; TIMER [16:0] target, [17] enable, [18] retrig; ALARM_CLOCK [21:0] time, [27:22] mask, [28] enable; ALARM_DATE full 32 bits; EVT_CLR [1:0]. Payload SHALL pass unmodified.
REQ-015 SHALL hold req/cmd/data stable on the requester side until gnt; gnt SHALL fire only when queue count < FIFO_DEPTH, evaluated before any same-cycle pop.
REQ-016 SHALL arbitrate round-robin: a single requester wins; with both requesting, the one not granted last wins; pointer at reset favours A.
REQ-017 SHALL write the granted command {src, cmd, data} into the queue at the gnt edge.
REQ-018 SHALL implement FSM states IDLE, HOLD, ISSUE.
REQ-019 In IDLE with queue non-empty: if head is CLOCK or ALARM_DATE and day_rollover_i=1, go to HOLD; otherwise pop and go to ISSUE.
REQ-020 In HOLD: on day_rollover_i=0, pop and go to ISSUE; no other head SHALL bypass it.
REQ-021 In ISSUE: exactly one upd_strobe_o bit SHALL be high for one cycle with upd_data_o and done_o/done_src_o; then go to IDLE.
REQ-022 All outputs SHALL be registered; grant-to-strobe latency SHALL be 2 cycles minimum with the queue empty, throughput one command per 2 cycles, and issue order SHALL be queue order.
REQ-023 upd_data_o SHALL be 0 whenever no strobe is active; busy_o SHALL be (queue non-empty) or (state != IDLE).
REQ-024 Queue pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from an explicit count.

Reset
REQ-025 rst_i SHALL asynchronously clear the queue, set the FSM to IDLE and the RR pointer to A, and drive all outputs to 0, including mid-HOLD or mid-ISSUE; queued commands SHALL be discarded.

Configuration
REQ-026 With RTC_SCHED_ERR_EN defined, a granted reserved command SHALL be consumed without a strobe, SHALL set err_o sticky (cleared only by reset), and SHALL pulse done_o.
REQ-027 Without RTC_SCHED_ERR_EN, a reserved command SHALL be dropped silently with no done_o, and err_o SHALL be tied to 0.

Structure
REQ-028 rtc_pkg SHALL hold the command enum, strobe index constants, payload field bit positions and the queue entry struct.
REQ-029 The queue SHALL be sub-module rtc_cmd_fifo (sync FIFO, count output); arbiter and FSM SHALL reside in the top level.

Verification
REQ-030 A CALIBRE 0x7FFF with the queue empty -> a_gnt_o at cycle 0, upd_strobe_o=6'b000010 and upd_data_o=0x00007FFF at cycle 2, done_src_o=0.
REQ-031 A and B both request continuously, 4 commands each -> grants alternate A,B,A,B..., and strobes follow the same order.
REQ-032 Queue filled to 4 while day_rollover_i=1 and head is CLOCK -> FSM stays in HOLD, 5th request gets no gnt, and on rollover fall the CLOCK strobe issues first, then the remaining 3.
REQ-033 TIMER head while day_rollover_i=1 -> issued without hold.
REQ-034 Reserved code 7 -> with macro: err_o=1, no strobe, done_o pulse; without macro: err_o=0, no done_o.
REQ-035 rst_i asserted in HOLD with 3 queued commands -> all outputs 0 immediately, busy_o=0, and no strobe after release.
